// File: rtl/axi4_rd_arbiter_if.sv
// axi4_rd_arbiter_if: requester command, response stream and AXI4 read-master signals of the two-port read arbiter
interface axi4_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid_i, req1_valid_i;
  logic [ADDR_W-1:0] req0_addr_i, req1_addr_i;
  logic [7:0]        req0_len_i, req1_len_i;
  logic              req0_ready_o, req1_ready_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic [1:0]        rsp_resp_o;
  logic              rsp_last_o, rsp_valid_o, rsp_owner_o, rsp_ready_i;
  logic              busy_o, err_o;
  logic [ADDR_W-1:0] M_AXI_ARADDR_o;
  logic [7:0]        M_AXI_ARLEN_o;
  logic [2:0]        M_AXI_ARSIZE_o;
  logic [1:0]        M_AXI_ARBURST_o;
  logic              M_AXI_ARVALID_o, M_AXI_ARREADY_i;
  logic [DATA_W-1:0] M_AXI_RDATA_i;
  logic [1:0]        M_AXI_RRESP_i;
  logic              M_AXI_RLAST_i, M_AXI_RVALID_i, M_AXI_RREADY_o;
  modport master (
    input  req0_valid_i, req1_valid_i, req0_addr_i, req1_addr_i, req0_len_i, req1_len_i, rsp_ready_i,
           M_AXI_ARREADY_i, M_AXI_RDATA_i, M_AXI_RRESP_i, M_AXI_RLAST_i, M_AXI_RVALID_i,
    output req0_ready_o, req1_ready_o, rsp_data_o, rsp_resp_o, rsp_last_o, rsp_valid_o, rsp_owner_o,
           busy_o, err_o, M_AXI_ARADDR_o, M_AXI_ARLEN_o, M_AXI_ARSIZE_o, M_AXI_ARBURST_o,
           M_AXI_ARVALID_o, M_AXI_RREADY_o
  );
  modport slave (
    output req0_valid_i, req1_valid_i, req0_addr_i, req1_addr_i, req0_len_i, req1_len_i, rsp_ready_i,
           M_AXI_ARREADY_i, M_AXI_RDATA_i, M_AXI_RRESP_i, M_AXI_RLAST_i, M_AXI_RVALID_i,
    input  req0_ready_o, req1_ready_o, rsp_data_o, rsp_resp_o, rsp_last_o, rsp_valid_o, rsp_owner_o,
           busy_o, err_o, M_AXI_ARADDR_o, M_AXI_ARLEN_o, M_AXI_ARSIZE_o, M_AXI_ARBURST_o,
           M_AXI_ARVALID_o, M_AXI_RREADY_o
  );
endinterface

// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter: round-robin share of one AXI4 read channel between two requesters.
// Define AXI_RD_ARB_CHECK_EN to enable the sticky beat-count error check on err_o.
module axi4_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  axi4_rd_arbiter_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [2:0] ASIZE = 3'($clog2(DATA_W/8));
  logic [1:0]        state;
  logic              prio, owner, grant1, in_idle, in_data, ar_hs, r_hs;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  assign in_idle = state == IDLE;
  assign in_data = state == DATA;
  // requester 1 wins when alone or when both contend and it holds the pointer
  assign grant1 = bus.req1_valid_i & (~bus.req0_valid_i | prio);
  assign ar_hs  = state == ADDR & bus.M_AXI_ARREADY_i;
  assign r_hs   = in_data & bus.M_AXI_RVALID_i & bus.rsp_ready_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      prio   <= 1'b0;
      owner  <= 1'b0;
      araddr <= '0;
      arlen  <= '0;
    end else if (in_idle) begin
      if (bus.req0_valid_i | bus.req1_valid_i) begin
        araddr <= grant1 ? bus.req1_addr_i : bus.req0_addr_i;
        arlen  <= grant1 ? bus.req1_len_i : bus.req0_len_i;
        owner  <= grant1;
        prio   <= ~grant1;
        state  <= ADDR;
      end
    end else if (ar_hs)
      state <= DATA;
    else if (r_hs & bus.M_AXI_RLAST_i)
      state <= IDLE;
  assign bus.req0_ready_o    = in_idle & bus.req0_valid_i & ~grant1;
  assign bus.req1_ready_o    = in_idle & grant1;
  assign bus.M_AXI_ARADDR_o  = araddr;
  assign bus.M_AXI_ARLEN_o   = arlen;
  assign bus.M_AXI_ARSIZE_o  = ASIZE;
  assign bus.M_AXI_ARBURST_o = 2'b01;
  assign bus.M_AXI_ARVALID_o = state == ADDR;
  assign bus.M_AXI_RREADY_o  = in_data & bus.rsp_ready_i;
  assign bus.rsp_valid_o     = in_data & bus.M_AXI_RVALID_i;
  assign bus.rsp_data_o      = in_data ? bus.M_AXI_RDATA_i : '0;
  assign bus.rsp_resp_o      = in_data ? bus.M_AXI_RRESP_i : 2'b00;
  assign bus.rsp_last_o      = in_data & bus.M_AXI_RLAST_i;
  assign bus.rsp_owner_o     = owner;
  assign bus.busy_o          = ~in_idle;
`ifdef AXI_RD_ARB_CHECK_EN
  logic [7:0] cnt;
  logic       err;
  // cnt is the index of the beat being handshaken; only index arlen may carry RLAST
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (ar_hs) cnt <= '0;
      else if (r_hs) cnt <= cnt + 8'd1;
      if (r_hs & (bus.M_AXI_RLAST_i ? cnt != arlen : cnt == arlen)) err <= 1'b1;
    end
  assign bus.err_o = err;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// tb_axi4_rd_arbiter: directed stimulus with AR/R scoreboards checked by a negedge monitor
module tb_axi4_rd_arbiter;
  typedef struct {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct {logic [31:0] data; logic [1:0] resp; logic last; logic own;} beat_t;
`ifdef AXI_RD_ARB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  int compared = 0, mismatched = 0;
  ar_t ar_q[$];
  beat_t r_q[$];
  logic own_exp = 1'b0;
  ar_t ma;
  beat_t mb;
  axi4_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  axi4_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endfunction
  always @(negedge clk) begin
    if (bus.M_AXI_ARVALID_o && bus.M_AXI_ARREADY_i) begin
      if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        ma = ar_q.pop_front();
        chk("araddr", bus.M_AXI_ARADDR_o, ma.addr);
        chk("arlen", bus.M_AXI_ARLEN_o, ma.len);
      end
    end
    if (bus.rsp_valid_o && bus.rsp_ready_i) begin
      if (r_q.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        mb = r_q.pop_front();
        chk("rsp_data", bus.rsp_data_o, mb.data);
        chk("rsp_resp", bus.rsp_resp_o, mb.resp);
        chk("rsp_last", bus.rsp_last_o, mb.last);
        chk("rsp_owner", bus.rsp_owner_o, mb.own);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  task automatic issue(input bit r, input logic [31:0] a, input logic [7:0] l);
    if (r) begin
      bus.req1_valid_i = 1'b1; bus.req1_addr_i = a; bus.req1_len_i = l;
    end else begin
      bus.req0_valid_i = 1'b1; bus.req0_addr_i = a; bus.req0_len_i = l;
    end
    @(negedge clk);
    chk("req0_ready", bus.req0_ready_o, !r);
    chk("req1_ready", bus.req1_ready_o, r);
    ar_q.push_back('{a, l});
    own_exp = r;
    tick();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
  endtask
  task automatic ar_accept(input int stall, input logic [31:0] a, input logic [7:0] l);
    bus.M_AXI_RVALID_i = 1'b1;
    bus.M_AXI_RDATA_i = 32'hdead_beef;
    bus.rsp_ready_i = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_arvalid", bus.M_AXI_ARVALID_o, 1);
      chk("stall_araddr", bus.M_AXI_ARADDR_o, a);
      chk("stall_arlen", bus.M_AXI_ARLEN_o, l);
      chk("stall_rready", bus.M_AXI_RREADY_o, 0);
      chk("stall_rsp_valid", bus.rsp_valid_o, 0);
      chk("stall_rsp_data", bus.rsp_data_o, 0);
      tick();
    end
    bus.M_AXI_RVALID_i = 1'b0;
    bus.M_AXI_RDATA_i = '0;
    bus.M_AXI_ARREADY_i = 1'b1;
    @(negedge clk);
    chk("arvalid", bus.M_AXI_ARVALID_o, 1);
    chk("arsize", bus.M_AXI_ARSIZE_o, 3'd2);
    chk("arburst", bus.M_AXI_ARBURST_o, 2'b01);
    chk("owner", bus.rsp_owner_o, own_exp);
    tick();
    bus.M_AXI_ARREADY_i = 1'b0;
  endtask
  task automatic send_r(input int n, input int last_at, input logic [31:0] base, input bit toggle);
    int i = 0, p = 0, g = 0;
    bit ph = 1'b1;
    while (i < n && g < 100) begin
      bus.M_AXI_RVALID_i = 1'b1;
      bus.M_AXI_RDATA_i = base + 32'(i);
      bus.M_AXI_RLAST_i = (i == last_at);
      bus.M_AXI_RRESP_i = 2'(i);
      bus.rsp_ready_i = toggle ? ph : 1'b1;
      ph = !ph;
      if (p == i) begin
        r_q.push_back('{base + 32'(i), 2'(i), i == last_at, own_exp});
        p++;
      end
      @(negedge clk);
      if (toggle) chk("rready_mirror", bus.M_AXI_RREADY_o, bus.rsp_ready_i);
      if (bus.M_AXI_RREADY_o) i++;
      g++;
      tick();
    end
    if (i < n) chk("r_timeout", i, n);
    bus.M_AXI_RVALID_i = 1'b0;
    bus.M_AXI_RLAST_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
  endtask
  task automatic idle_check(input string n);
    @(negedge clk);
    chk(n, bus.busy_o, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    bus.req0_valid_i = 0; bus.req1_valid_i = 0; bus.req0_addr_i = 0; bus.req1_addr_i = 0;
    bus.req0_len_i = 0; bus.req1_len_i = 0; bus.rsp_ready_i = 0; bus.M_AXI_ARREADY_i = 0;
    bus.M_AXI_RDATA_i = 0; bus.M_AXI_RRESP_i = 0; bus.M_AXI_RLAST_i = 0; bus.M_AXI_RVALID_i = 0;
    #12;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_arvalid", bus.M_AXI_ARVALID_o, 0);
    chk("rst_araddr", bus.M_AXI_ARADDR_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_err", bus.err_o, 0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(0, 32'h1000, 8'd3);
    ar_accept(0, 32'h1000, 8'd3);
    send_r(4, 3, 32'h100, 0);
    idle_check("t1_busy_drop");
    chk("t1_err", bus.err_o, 0);
    tick();
    do_reset();
    bus.req0_valid_i = 1; bus.req0_addr_i = 32'h2000; bus.req0_len_i = 0;
    bus.req1_valid_i = 1; bus.req1_addr_i = 32'h3000; bus.req1_len_i = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("c_ready0", bus.req0_ready_o, k % 2 == 0);
      chk("c_ready1", bus.req1_ready_o, k % 2 == 1);
      own_exp = k[0];
      ar_q.push_back('{k[0] ? 32'h3000 : 32'h2000, 8'd0});
      tick();
      ar_accept(0, 0, 0);
      send_r(1, 0, 32'h200 + 32'(k) * 32'h10, 0);
    end
    bus.req0_valid_i = 0;
    bus.req1_valid_i = 0;
    idle_check("t2_idle");
    tick();
    issue(1, 32'h4000, 8'd2);
    ar_accept(5, 32'h4000, 8'd2);
    send_r(3, 2, 32'h400, 0);
    idle_check("t3_idle");
    tick();
    issue(0, 32'ha000, 8'd7);
    ar_accept(0, 32'ha000, 8'd7);
    send_r(8, 7, 32'ha00, 1);
    idle_check("t4_idle");
    chk("t4_err", bus.err_o, 0);
    tick();
    issue(1, 32'h6000, 8'd3);
    ar_accept(0, 32'h6000, 8'd3);
    send_r(2, -1, 32'h600, 0);
    bus.M_AXI_RVALID_i = 1; bus.M_AXI_RDATA_i = 32'h602; bus.rsp_ready_i = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", bus.busy_o, 0);
    chk("ar_arvalid", bus.M_AXI_ARVALID_o, 0);
    chk("ar_rready", bus.M_AXI_RREADY_o, 0);
    chk("ar_rsp_valid", bus.rsp_valid_o, 0);
    chk("ar_rsp_data", bus.rsp_data_o, 0);
    chk("ar_owner", bus.rsp_owner_o, 0);
    chk("ar_araddr", bus.M_AXI_ARADDR_o, 0);
    chk("ar_arlen", bus.M_AXI_ARLEN_o, 0);
    bus.M_AXI_RVALID_i = 0; bus.M_AXI_RDATA_i = 0; bus.rsp_ready_i = 0;
    tick();
    rst_n = 1'b1;
    tick();
    issue(0, 32'h7000, 8'd1);
    ar_accept(0, 32'h7000, 8'd1);
    send_r(2, 1, 32'h700, 0);
    idle_check("t5_idle");
    tick();
    issue(0, 32'h8000, 8'd3);
    ar_accept(0, 32'h8000, 8'd3);
    send_r(3, 2, 32'h800, 0);
    @(negedge clk);
    chk("t6_err", bus.err_o, CHK);
    tick();
    issue(1, 32'h9000, 8'd0);
    ar_accept(0, 32'h9000, 8'd0);
    send_r(1, 0, 32'h900, 0);
    @(negedge clk);
    chk("t6_err_sticky", bus.err_o, CHK);
    chk("ar_q_empty", ar_q.size(), 0);
    chk("r_q_empty", r_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axi4_rd_arbiter.md
# axi4_rd_arbiter

Round-robin arbiter that shares one AXI4 master read channel (AR/R) between two local requesters. Each requester hands over a single burst command (address, length); the arbiter issues it on the master AR channel, streams the R beats back to the owner with backpressure, and accepts the next command only after RLAST. It sits between the block-internal read clients and the M_AXI read port; the write channels are untouched.

## Interface
- ADDR_W, 32, AR address width
- DATA_W, 32, R data width; power of two, 8..1024
- clk  input  1  clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid_i / req1_valid_i  input  1  command valid per requester
- req0_addr_i / req1_addr_i  input  ADDR_W  burst start address
- req0_len_i / req1_len_i  input  8  AXI ARLEN (beats-1)
- req0_ready_o / req1_ready_o  output  1  command accepted this cycle
- rsp_data_o  output  DATA_W  read data to owner
- rsp_resp_o  output  2  RRESP passthrough
- rsp_last_o  output  1  last beat
- rsp_valid_o  output  1  beat valid
- rsp_owner_o  output  1  requester index owning current burst
- rsp_ready_i  input  1  owner accepts beat
- busy_o  output  1  burst in flight (state != IDLE)
- err_o  output  1  sticky beat-count error (see Configuration)
- M_AXI_ARADDR_o  output  ADDR_W; M_AXI_ARLEN_o  output  8; M_AXI_ARSIZE_o  output  3; M_AXI_ARBURST_o  output  2; M_AXI_ARVALID_o  output  1; M_AXI_ARREADY_i  input  1
- M_AXI_RDATA_i  input  DATA_W; M_AXI_RRESP_i  input  2; M_AXI_RLAST_i  input  1; M_AXI_RVALID_i  input  1; M_AXI_RREADY_o  output  1

## Operation
- FSM states IDLE, ADDR, DATA; reset state IDLE.
- IDLE: if any reqN_valid_i, grant one: single valid wins; both valid -> requester equal to priority pointer prio wins. Assert granted reqN_ready_o (combinational, IDLE only), latch addr/len into AR registers, set rsp_owner_o, go ADDR. Ungranted ready stays 0.
- prio reset 0; after each grant prio <= ~granted index (strict alternation under contention).
- ADDR: M_AXI_ARVALID_o=1, address/length held stable until M_AXI_ARREADY_i; on handshake go DATA.
- DATA: M_AXI_RREADY_o = rsp_ready_i; rsp_valid_o = M_AXI_RVALID_i; rsp_data/resp/last = R inputs (combinational passthrough, no buffering). On RVALID&RREADY&RLAST go IDLE.
- ARBURST constant 2'b01 (INCR); ARSIZE constant log2(DATA_W/8).
- Reset values: all ready/valid outputs 0, ARADDR 0, ARLEN 0, rsp_owner_o 0, busy_o 0, err_o 0.
- Reset asserted mid-burst: immediate return to IDLE, ARVALID/RREADY drop, burst abandoned (interconnect is reset with it).
- rsp_* outputs outside DATA: valid 0, data/resp/last 0.

## Timing
- Command handshake cycle N -> ARVALID high cycle N+1.
- AR handshake cycle M -> RREADY may be high from cycle M+1.
- Last-beat handshake cycle L -> IDLE at L+1; next command accepted earliest L+1, ARVALID L+2.
- One burst outstanding at a time; R beat throughput 1/cycle when RVALID and rsp_ready_i both high.
- ARREADY stall of any length holds ADDR with all AR outputs unchanged.

## Configuration
- AXI_RD_ARB_CHECK_EN defined: 8-bit beat counter cleared on AR handshake, incremented per R handshake; err_o set (sticky until reset) when RLAST arrives with count != ARLEN, or when count == ARLEN beat lacks RLAST. FSM still exits only on RLAST.
- Undefined: no counter, err_o tied 0.

## Test plan
- req0 alone, addr 0x1000, len 3, ARREADY immediate, RVALID every cycle -> ARVALID cycle after ready, 4 beats to owner 0, busy_o drops cycle after RLAST.
- req0 and req1 valid together continuously, len 0 each -> grants 0,1,0,1; rsp_owner_o alternates.
- ARREADY held low 5 cycles -> ARADDR/ARLEN/ARVALID stable all 5 cycles, no R accepted.
- rsp_ready_i toggled 1/0 during len 7 burst -> RREADY mirrors it, 8 beats delivered in order, none dropped.
- rst_n pulsed low during DATA beat 2 -> all outputs return to reset values asynchronously, next req accepted from IDLE.
- With AXI_RD_ARB_CHECK_EN, len 3 burst with RLAST on beat 2 -> err_o rises and stays 1; without macro err_o stays 0.
